picorv_mem_arbiter: RTL and testbench

PICORV_MEM_ARBITER -- requirements
Module: picorv_mem_arbiter

---
 rtl/picorv_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_picorv_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : picorv_mem_arbiter
// Brief    : Round-robin arbiter sharing one picorv32-style memory port
//            between two requesters, with a bounded wait and error completion.
// Revision : 1.0  initial release
// ============================================================================
module picorv_mem_arbiter #(
    parameter logic [15:0] TIMEOUT   = 16'd1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] c_LIMIT = TIMEOUT - 16'd1;

    state_t      r_state;
    logic [15:0] r_count;
    logic        r_last;

    logic        w_pick;
    logic        w_done;
    logic [31:0] w_resp_data;

    // A lone requester always wins; on a tie the one not served last wins.
    assign w_pick      = m1_valid & (~m0_valid | ~r_last);
    assign w_done      = mem_ready | (r_count == c_LIMIT);
    assign w_resp_data = mem_ready ? mem_rdata : ERR_RDATA;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_count     <= 16'd0;
            r_last      <= 1'b1;
            mem_valid   <= 1'b0;
            mem_instr   <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_wstrb   <= 4'h0;
            m0_ready    <= 1'b0;
            m0_rdata    <= 32'h0;
            m1_ready    <= 1'b0;
            m1_rdata    <= 32'h0;
            grant       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant     <= w_pick;
                        mem_instr <= w_pick ? m1_instr : m0_instr;
                        mem_addr  <= w_pick ? m1_addr  : m0_addr;
                        mem_wdata <= w_pick ? m1_wdata : m0_wdata;
                        mem_wstrb <= w_pick ? m1_wstrb : m0_wstrb;
                        mem_valid <= 1'b1;
                        r_count   <= 16'd0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A real ready in the final allowed cycle beats the timeout.
                    if (w_done) begin
                        mem_valid   <= 1'b0;
                        timeout_err <= ~mem_ready;
                        r_last      <= grant;
                        r_state     <= S_RESP;
                        if (grant) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= w_resp_data;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= w_resp_data;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                S_RESP: begin
                    m0_ready    <= 1'b0;
                    m1_ready    <= 1'b0;
                    timeout_err <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_picorv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv_mem_arbiter
// Brief    : Directed scoreboard bench for picorv_mem_arbiter (TIMEOUT=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_picorv_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        grant, timeout_err;

    picorv_mem_arbiter #(
        .TIMEOUT   (16'd4),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0_valid    (m0_valid),
        .m0_instr    (m0_instr),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wstrb    (m0_wstrb),
        .m0_ready    (m0_ready),
        .m0_rdata    (m0_rdata),
        .m1_valid    (m1_valid),
        .m1_instr    (m1_instr),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wstrb    (m1_wstrb),
        .m1_ready    (m1_ready),
        .m1_rdata    (m1_rdata),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ready is asserted r_lat+1 sampled cycles after mem_valid.
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem [32];

    always @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
            mem_cnt   <= 0;
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'hA0A0_0001;
            mem[2]  <= 32'hB1B1_0002;
            mem[4]  <= 32'h1234_5678;
            mem[8]  <= 32'h1122_3344;
            mem[12] <= 32'h0000_0001;
        end else if (mem_valid && !mem_ready) begin
            if (mem_cnt == mem_lat) begin
                mem_ready <= 1'b1;
                mem_cnt   <= 0;
                if (mem_wstrb == 4'h0) begin
                    mem_rdata <= mem[mem_addr[6:2]];
                end else begin
                    mem_rdata <= 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[6:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          terr;
    } exp_t;

    exp_t        q[$];
    int          vectors;
    int          miscompares;
    logic [31:0] last_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit p, input logic [31:0] rd, input bit te);
        exp_t e;
        e.port  = p;
        e.rdata = rd;
        e.terr  = te;
        q.push_back(e);
    endtask

    task automatic drive(input bit p, input logic v, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (p) begin
            m1_valid = v; m1_instr = instr; m1_addr = addr; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_valid = v; m0_instr = instr; m0_addr = addr; m0_wdata = wd; m0_wstrb = ws;
        end
    endtask

    // Issue one request, hold it until its ready pulse, and check downstream fields.
    task automatic req(input bit p, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] erd, input bit ete,
                       output int lat, output int mv, output int pulses);
        logic prev_mv;
        logic rdy;
        push(p, erd, ete);
        @(negedge clk);
        drive(p, 1'b1, instr, addr, wd, ws);
        lat = 0; mv = 0; pulses = 0; prev_mv = mem_valid; rdy = 1'b0;
        while (!rdy && lat < 60) begin
            @(negedge clk);
            lat++;
            if (mem_valid) begin
                mv++;
                if (!prev_mv) pulses++;
                chk("mem_addr",  mem_addr,  addr);
                chk("mem_wdata", mem_wdata, wd);
                chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, ws});
                chk("mem_instr", {31'h0, mem_instr}, {31'h0, instr});
            end
            prev_mv = mem_valid;
            rdy = p ? m1_ready : m0_ready;
        end
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL req_wait: got no ready after %0d cycles, expected ready", lat);
        end
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Scoreboard monitor: pops one expectation per ready pulse.
    initial begin
        exp_t e;
        bit   p;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                last_rd[0] = 32'h0;
                last_rd[1] = 32'h0;
            end else if (m0_ready || m1_ready) begin
                chk("single_ready", {31'h0, m0_ready & m1_ready}, 32'h0);
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ready: got m0_ready=%b m1_ready=%b, expected none",
                             m0_ready, m1_ready);
                end else begin
                    e = q.pop_front();
                    p = m1_ready;
                    chk("served_port", {31'h0, p}, {31'h0, e.port});
                    chk("rdata", p ? m1_rdata : m0_rdata, e.rdata);
                    chk("timeout_err", {31'h0, timeout_err}, {31'h0, e.terr});
                    chk("grant", {31'h0, grant}, {31'h0, e.port});
                    chk("mem_valid_in_resp", {31'h0, mem_valid}, 32'h0);
                    chk("other_rdata_hold", p ? m0_rdata : m1_rdata, last_rd[p ? 0 : 1]);
                    last_rd[p ? 1 : 0] = e.rdata;
                end
            end
        end
    end

    initial begin
        int lat, mv, pulses, served, cyc;
        vectors = 0;
        miscompares = 0;
        mem_lat = 0;
        resetn = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);

        // Reset values while both requesters are already asking.
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst_mem_instr", {31'h0, mem_instr}, 32'h0);
        chk("rst_readys", {30'h0, m1_ready, m0_ready}, 32'h0);
        chk("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
        chk("rst_grant", {31'h0, grant}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);

        // Contention: m0, m1, m0, m1.
        push(1'b0, 32'hA0A0_0001, 1'b0);
        push(1'b1, 32'hB1B1_0002, 1'b0);
        push(1'b0, 32'hA0A0_0001, 1'b0);
        push(1'b1, 32'hB1B1_0002, 1'b0);
        resetn = 1'b1;
        served = 0; cyc = 0; pulses = 0;
        while (served < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (m0_ready || m1_ready) served++;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("contention_served", served, 32'd4);

        // Single instruction-fetch read, 3 cycles valid-to-ready.
        req(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0, lat, mv, pulses);
        chk("read_latency", lat, 32'd3);
        chk("read_mem_valid_pulses", pulses, 32'd1);

        // Partial write from m1, then readback through m0.
        req(1'b1, 1'b0, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, lat, mv, pulses);
        chk("write_latency", lat, 32'd3);
        req(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, lat, mv, pulses);

        // Timeout with a memory that never answers.
        mem_lat = 1000;
        req(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, lat, mv, pulses);
        chk("timeout_mem_valid_cycles", mv, 32'd4);
        chk("timeout_latency", lat, 32'd5);
        @(negedge clk);
        chk("timeout_back_idle", {31'h0, mem_valid | timeout_err}, 32'h0);

        // Ready lands in the 4th BUSY cycle: normal completion wins.
        mem_lat = 2;
        req(1'b0, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h0000_0001, 1'b0, lat, mv, pulses);
        chk("tie_mem_valid_cycles", mv, 32'd4);

        // Reset in the middle of BUSY: no ready, then a fresh m1 read.
        mem_lat = 1000;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("busy_before_reset", {31'h0, mem_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("async_reset_mem_valid", {31'h0, mem_valid}, 32'h0);
        repeat (2) @(negedge clk);
        mem_lat = 0;
        resetn = 1'b1;
        req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 1'b0, lat, mv, pulses);
        chk("post_reset_latency", lat, 32'd3);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
